// File: rtl/y86_bus_mem_if.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// y86_bus_mem_if : CPU bus and program-loader signals of y86_bus_mem
// Rev 1.0
// =====================================================================
interface y86_bus_mem_if;
   logic [31:0] bus_A;
   logic [31:0] bus_out;
   logic        bus_WE;
   logic        bus_RE;
   logic [31:0] bus_in;
   logic        ld_start;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic        ld_ready;

   modport master (
      output bus_A, bus_out, bus_WE, bus_RE, ld_start, ld_valid, ld_data, ld_last,
      input  bus_in, ld_ready
   );

   modport slave (
      input  bus_A, bus_out, bus_WE, bus_RE, ld_start, ld_valid, ld_data, ld_last,
      output bus_in, ld_ready
   );
endinterface
`default_nettype wire

// File: rtl/y86_bus_mem.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// y86_bus_mem : byte-addressed little-endian RAM with program loader,
//               unaligned 32-bit CPU access and saturating access counters
// Rev 1.0
// =====================================================================
module y86_bus_mem #(
   parameter int ADDR_BITS = 10,
   parameter int CNT_BITS  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   y86_bus_mem_if.slave        bus,
   output logic                cpu_run,
   output logic                addr_err,
   output logic [CNT_BITS-1:0] rd_count,
   output logic [CNT_BITS-1:0] wr_count
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam int MEM_BYTES = 1 << ADDR_BITS;

   logic [1:0]           state;
   logic [ADDR_BITS-1:0] ptr;
   logic [7:0]           mem [MEM_BYTES];

   logic [32:0] byte_addr [4];
   logic [3:0]  in_range;
   logic [31:0] rd_data;
   logic        cpu_phase;
   logic        cpu_rd;
   logic        cpu_wr;
   logic        ld_accept;
   logic        ld_overflow;

   // 33-bit lane addresses so bus_A near 2^32 cannot wrap back into range
   always_comb begin
      rd_data  = 32'h0;
      in_range = 4'h0;
      for (int k = 0; k < 4; k++) begin
         byte_addr[k] = {1'b0, bus.bus_A} + 33'(k);
         in_range[k]  = (byte_addr[k] >> ADDR_BITS) == 33'd0;
         rd_data[8*k +: 8] = in_range[k] ? mem[byte_addr[k][ADDR_BITS-1:0]] : 8'h00;
      end
   end

   assign cpu_phase   = (state != ST_LOAD);
   assign cpu_rd      = cpu_phase && bus.bus_RE;
   assign cpu_wr      = cpu_phase && bus.bus_WE;
   // ld_start wins over a same-cycle loader byte, so the byte is not handshaken
   assign ld_accept   = (state == ST_LOAD) && bus.ld_valid && !bus.ld_start;
   assign ld_overflow = ld_accept && (&ptr) && !bus.ld_last;

   assign bus.bus_in   = cpu_rd ? rd_data : 32'h0;
   assign bus.ld_ready = (state == ST_LOAD) && !bus.ld_start;
   assign cpu_run      = (state == ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         rd_count <= '0;
         wr_count <= '0;
         addr_err <= 1'b0;
      end else if (bus.ld_start) begin
         state    <= ST_LOAD;
         ptr      <= '0;
         rd_count <= '0;
         wr_count <= '0;
         addr_err <= 1'b0;
      end else begin
         if (ld_accept) begin
            ptr <= ptr + 1'b1;
            if (bus.ld_last || (&ptr))
               state <= ST_RUN;
            if (ld_overflow)
               addr_err <= 1'b1;
         end
         if ((cpu_rd || cpu_wr) && !(&in_range))
            addr_err <= 1'b1;
         if (cpu_rd && (rd_count != '1))
            rd_count <= rd_count + 1'b1;
         if (cpu_wr && (wr_count != '1))
            wr_count <= wr_count + 1'b1;
      end
   end

   // RAM has no reset: contents survive rst_n and an abandoned load
   always_ff @(posedge clk) begin
      if (ld_accept) begin
         mem[ptr] <= bus.ld_data;
      end else if (cpu_wr && !bus.ld_start) begin
         for (int k = 0; k < 4; k++) begin
            if (in_range[k])
               mem[byte_addr[k][ADDR_BITS-1:0]] <= bus.bus_out[8*k +: 8];
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_y86_bus_mem.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// tb_y86_bus_mem : directed stimulus with a queued-expectation scoreboard
// Rev 1.0
// =====================================================================
module tb_y86_bus_mem;
   localparam int SEL_BUS = 0;
   localparam int SEL_RUN = 1;
   localparam int SEL_RDY = 2;
   localparam int SEL_ERR = 3;
   localparam int SEL_RDC = 4;
   localparam int SEL_WRC = 5;
   localparam int SEL_SAT = 6;

   logic        clk;
   logic        rst_n;
   logic        cpu_run;
   logic        addr_err;
   logic [15:0] rd_count;
   logic [15:0] wr_count;
   logic        sat_run;
   logic        sat_err;
   logic [1:0]  sat_rd;
   logic [1:0]  sat_wr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   y86_bus_mem_if bif();
   y86_bus_mem_if sif();

   y86_bus_mem #(.ADDR_BITS(10), .CNT_BITS(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bif.slave),
      .cpu_run  (cpu_run),
      .addr_err (addr_err),
      .rd_count (rd_count),
      .wr_count (wr_count)
   );

   // narrow counters make saturation reachable in a handful of reads
   y86_bus_mem #(.ADDR_BITS(10), .CNT_BITS(2)) dut_sat (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (sif.slave),
      .cpu_run  (sat_run),
      .addr_err (sat_err),
      .rd_count (sat_rd),
      .wr_count (sat_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SEL_BUS: return bif.bus_in;
         SEL_RUN: return {31'b0, cpu_run};
         SEL_RDY: return {31'b0, bif.ld_ready};
         SEL_ERR: return {31'b0, addr_err};
         SEL_RDC: return {16'b0, rd_count};
         SEL_WRC: return {16'b0, wr_count};
         SEL_SAT: return {30'b0, sat_rd};
         default: return 32'hXXXX_XXXX;
      endcase
   endfunction

   // Monitor: every falling edge drains whatever the stimulus has queued
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = observe(e.sel);
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic expect_val(input string name, input int sel, input logic [31:0] v);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
      bif.bus_A   = a;
      bif.bus_out = d;
      bif.bus_WE  = 1'b1;
      tick();
      bif.bus_WE  = 1'b0;
   endtask

   task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp, input string name);
      bif.bus_A  = a;
      bif.bus_RE = 1'b1;
      expect_val(name, SEL_BUS, exp);
      tick();
      bif.bus_RE = 1'b0;
   endtask

   task automatic ld_byte(input logic [7:0] d, input logic last);
      bif.ld_valid = 1'b1;
      bif.ld_data  = d;
      bif.ld_last  = last;
      tick();
      bif.ld_valid = 1'b0;
      bif.ld_last  = 1'b0;
   endtask

   task automatic ld_start_pulse();
      bif.ld_start = 1'b1;
      tick();
      bif.ld_start = 1'b0;
   endtask

   initial begin
      logic [1:0] sat_exp [5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      bif.bus_A = '0; bif.bus_out = '0; bif.bus_WE = 1'b0; bif.bus_RE = 1'b0;
      bif.ld_start = 1'b0; bif.ld_valid = 1'b0; bif.ld_data = '0; bif.ld_last = 1'b0;
      sif.bus_A = '0; sif.bus_out = '0; sif.bus_WE = 1'b0; sif.bus_RE = 1'b0;
      sif.ld_start = 1'b0; sif.ld_valid = 1'b0; sif.ld_data = '0; sif.ld_last = 1'b0;
      rst_n = 1'b0;
      tick();
      expect_val("rst_cpu_run",  SEL_RUN, 32'd0);
      expect_val("rst_ld_ready", SEL_RDY, 32'd0);
      expect_val("rst_addr_err", SEL_ERR, 32'd0);
      expect_val("rst_rd_count", SEL_RDC, 32'd0);
      expect_val("rst_wr_count", SEL_WRC, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // known RAM contents around the addresses used below
      cpu_write(32'h0,   32'h0);
      cpu_write(32'h4,   32'h0);
      cpu_write(32'h8,   32'h0);
      cpu_write(32'h3FC, 32'hA5A5_1234);

      // saturating read counter on the narrow instance
      sif.bus_RE = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_val($sformatf("sat_rd_%0d", i), SEL_SAT, {30'b0, sat_exp[i]});
      end
      sif.bus_RE = 1'b0;

      // three-byte program load
      ld_start_pulse();
      expect_val("load_ready", SEL_RDY, 32'd1);
      expect_val("load_run",   SEL_RUN, 32'd0);
      ld_byte(8'h01, 1'b0);
      ld_byte(8'hD8, 1'b0);
      ld_byte(8'hF4, 1'b1);
      expect_val("run_after_last",   SEL_RUN, 32'd1);
      expect_val("ready_after_last", SEL_RDY, 32'd0);
      cpu_read(32'h0, 32'h00F4_D801, "read_a0");
      cpu_read(32'h1, 32'h0000_F4D8, "read_a1");
      expect_val("no_strobe_bus_zero", SEL_BUS, 32'd0);
      tick();

      // write then unaligned reads
      cpu_write(32'h5, 32'hDEAD_BEEF);
      cpu_read(32'h5, 32'hDEAD_BEEF, "read_a5");
      cpu_read(32'h6, 32'h00DE_ADBE, "read_a6");
      expect_val("wr_count_1", SEL_WRC, 32'd1);
      expect_val("rd_count_4", SEL_RDC, 32'd4);
      expect_val("err_clear",  SEL_ERR, 32'd0);

      // simultaneous read and write returns pre-write data
      bif.bus_A = 32'h5; bif.bus_out = 32'h1122_3344;
      bif.bus_WE = 1'b1; bif.bus_RE = 1'b1;
      expect_val("rmw_old_data", SEL_BUS, 32'hDEAD_BEEF);
      tick();
      bif.bus_WE = 1'b0; bif.bus_RE = 1'b0;
      cpu_read(32'h5, 32'h1122_3344, "rmw_new_data");
      expect_val("rmw_rd_count", SEL_RDC, 32'd6);
      expect_val("rmw_wr_count", SEL_WRC, 32'd2);

      // top-of-RAM boundary
      bif.bus_A = 32'h3FE; bif.bus_RE = 1'b1;
      expect_val("oob_read_data",   SEL_BUS, 32'h0000_A5A5);
      expect_val("oob_err_pre_edge", SEL_ERR, 32'd0);
      tick();
      bif.bus_RE = 1'b0;
      expect_val("oob_err_set", SEL_ERR, 32'd1);
      cpu_write(32'h400, 32'hFFFF_FFFF);
      cpu_read(32'h3FC, 32'hA5A5_1234, "oob_write_dropped");
      cpu_write(32'h3FE, 32'h7766_5544);
      cpu_read(32'h3FC, 32'h5544_1234, "partial_write");
      expect_val("err_sticky", SEL_ERR, 32'd1);

      // ld_start clears flags; CPU strobes ignored during LOAD
      ld_start_pulse();
      expect_val("restart_err",   SEL_ERR, 32'd0);
      expect_val("restart_rdc",   SEL_RDC, 32'd0);
      expect_val("restart_wrc",   SEL_WRC, 32'd0);
      expect_val("restart_ready", SEL_RDY, 32'd1);
      bif.bus_A = 32'h3FE; bif.bus_out = 32'hFFFF_FFFF;
      bif.bus_RE = 1'b1; bif.bus_WE = 1'b1;
      expect_val("load_bus_zero", SEL_BUS, 32'd0);
      tick();
      bif.bus_RE = 1'b0; bif.bus_WE = 1'b0;
      expect_val("load_no_err", SEL_ERR, 32'd0);
      expect_val("load_no_rdc", SEL_RDC, 32'd0);
      expect_val("load_no_wrc", SEL_WRC, 32'd0);

      // full-RAM stream with no ld_last
      for (int i = 0; i < 1024; i++) begin
         ld_byte(8'(i) ^ 8'h5A, 1'b0);
         if (i == 1022) begin
            expect_val("stream_still_load", SEL_RDY, 32'd1);
            expect_val("stream_no_err",     SEL_ERR, 32'd0);
         end
      end
      expect_val("overflow_run", SEL_RUN, 32'd1);
      expect_val("overflow_err", SEL_ERR, 32'd1);
      expect_val("overflow_rdy", SEL_RDY, 32'd0);
      cpu_read(32'h0,   32'h5958_5B5A, "stream_a0");
      cpu_read(32'h3FC, 32'hA5A4_A7A6, "stream_a3fc");
      ld_start_pulse();
      expect_val("reload_err_clear", SEL_ERR, 32'd0);
      expect_val("reload_ready",     SEL_RDY, 32'd1);
      expect_val("reload_not_run",   SEL_RUN, 32'd0);

      // reset mid-load after two bytes, with CPU strobes active
      bif.bus_A = 32'h10; bif.bus_out = 32'hFFFF_FFFF;
      bif.bus_RE = 1'b1; bif.bus_WE = 1'b1;
      expect_val("midload_bus_zero", SEL_BUS, 32'd0);
      ld_byte(8'hC3, 1'b0);
      ld_byte(8'h3C, 1'b0);
      bif.bus_RE = 1'b0; bif.bus_WE = 1'b0;
      rst_n = 1'b0;
      expect_val("async_rst_run",   SEL_RUN, 32'd0);
      expect_val("async_rst_ready", SEL_RDY, 32'd0);
      expect_val("async_rst_rdc",   SEL_RDC, 32'd0);
      expect_val("async_rst_wrc",   SEL_WRC, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      cpu_read(32'h0,  32'h5958_3CC3, "after_rst_a0");
      cpu_read(32'h10, 32'h4948_4B4A, "after_rst_a10");
      expect_val("after_rst_rdc", SEL_RDC, 32'd2);
      expect_val("after_rst_wrc", SEL_WRC, 32'd0);
      expect_val("after_rst_run", SEL_RUN, 32'd0);

      repeat (2) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
